// File: rtl/stopwatch_pkg.sv
// Shared types and segment patterns for the stopwatch display path.
// Patterns are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RST,
    GAP,
    SHOW
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low 7-segment pattern; A-F show a dash.
// Ports: bcd (4-bit digit in), seg (7-bit {g..a} out).
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_scan_display.sv
// Multiplexed common-anode 7-seg scanner with per-frame digit snapshot.
// Ports: invCP (falling-edge clk), invCLR (async low reset), DIGITS,
// invHOLD (low freezes snapshot), AN/SEG/DP (active-low), FRAME.
// Option: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module stopwatch_scan_display
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter logic [NUM_DIGITS-1:0] DP_MASK = 4'b0100
) (
  input  logic                    invCP,
  input  logic                    invCLR,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic                    invHOLD,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    FRAME
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_t                  state;
  state_t                  state_n;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_n;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_n;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    latch;

  bcd_t                    nib;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    latch   = 1'b0;
    unique case (state)
      RST: begin
        state_n = GAP;
        idx_n   = '0;
        cnt_n   = '0;
        latch   = 1'b1;
      end
      GAP: begin
        state_n = SHOW;
        cnt_n   = '0;
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = GAP;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            latch = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RST;
    endcase
  end

  always_ff @(negedge invCP or negedge invCLR) begin
    if (!invCLR) begin
      state <= RST;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(negedge invCP or negedge invCLR) begin
    if (!invCLR) begin
      snap <= '0;
    end else if (latch && invHOLD) begin
      snap <= DIGITS;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; stop at the first nonzero.
  // Digit 0 always stays lit so a zero time still shows "0".
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] d
  );
    logic                  run;
    logic [NUM_DIGITS-1:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (run && d[4*i +: 4] == 4'd0) begin
        m[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return m;
  endfunction

  always_ff @(negedge invCP or negedge invCLR) begin
    if (!invCLR) begin
      blank <= '0;
    end else if (latch && invHOLD) begin
      blank <= lz_mask(DIGITS);
    end
  end
`else
  assign blank = '0;
`endif

  // snap/blank only move on edges entering GAP, so on any edge
  // entering or staying in SHOW the current registers are final.
  assign nib = snap[{idx_n, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .bcd (nib),
    .seg (seg_dec)
  );

  always_comb begin
    an_n  = '1;
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    if (state_n == SHOW) begin
      an_n = ~(NUM_DIGITS'(1) << idx_n);
      if (!blank[idx_n]) begin
        seg_n = seg_dec;
        dp_n  = ~DP_MASK[idx_n];
      end
    end
  end

  always_ff @(negedge invCP or negedge invCLR) begin
    if (!invCLR) begin
      AN    <= '1;
      SEG   <= SEG_OFF;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      AN    <= an_n;
      SEG   <= seg_n;
      DP    <= dp_n;
      FRAME <= latch;
    end
  end

endmodule

// File: tb/tb_stopwatch_scan_display.sv
// Bench for stopwatch_scan_display: frame-table vectors + scoreboard.
// Build with +define+LEADING_ZERO_BLANK_EN to cover the blanking option.
module tb_stopwatch_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FP = ND * (SD + 1);
  localparam logic [3:0] DPM = 4'b0100;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic        invCP = 1'b1;
  logic        invCLR = 1'b0;
  logic        invHOLD = 1'b1;
  logic [15:0] DIGITS = 16'h0000;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  initial forever #5 invCP = ~invCP;

  stopwatch_scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DP_MASK    (DPM)
  ) dut (
    .invCP   (invCP),
    .invCLR  (invCLR),
    .DIGITS  (DIGITS),
    .invHOLD (invHOLD),
    .AN      (AN),
    .SEG     (SEG),
    .DP      (DP),
    .FRAME   (FRAME)
  );

  typedef struct packed {
    logic [15:0]     digits;
    logic            hold;
    logic [3:0][6:0] seg;
    logic [3:0]      blank;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  vec_t            tbl[$];
  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              k = 0;
  logic            tracking = 1'b0;
  logic [3:0][6:0] exp_seg;
  logic [3:0]      exp_blank;
  logic [3:0]      dpm_v = DPM;

  function automatic vec_t mk(
    input logic [15:0] dg, input logic h,
    input logic [6:0] s3, input logic [6:0] s2,
    input logic [6:0] s1, input logic [6:0] s0,
    input logic [3:0] bl
  );
    vec_t v;
    v.digits = dg;
    v.hold   = h;
    v.seg[3] = s3;
    v.seg[2] = s2;
    v.seg[1] = s1;
    v.seg[0] = s0;
    v.blank  = bl;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    DIGITS    = v.digits;
    invHOLD   = v.hold;
    exp_seg   = v.seg;
    exp_blank = v.blank;
  endtask

  // One clock: predict this falling edge, then compare at the rising edge.
  task automatic step();
    exp_t e;
    int p, d, s;
    @(negedge invCP);
    if (tracking) begin
      p = k % FP;
      d = p / (SD + 1);
      s = p % (SD + 1);
      e.frame = (p == 0);
      e.an    = 4'hF;
      e.seg   = SOFF;
      e.dp    = 1'b1;
      if (s != 0) begin
        e.an  = ~(4'b0001 << d);
        e.seg = exp_seg[d];
        e.dp  = exp_blank[d] ? 1'b1 : ~dpm_v[d];
      end
      sbq.push_back(e);
      k++;
    end
    @(posedge invCP);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({AN, SEG, DP, FRAME} !== {e.an, e.seg, e.dp, e.frame}) begin
        errors++;
        $display("FAIL scan edge %0d: got AN=%b SEG=%b DP=%b FRAME=%b exp AN=%b SEG=%b DP=%b FRAME=%b",
                 k - 1, AN, SEG, DP, FRAME, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  task automatic check_rst(input string name);
    checks++;
    if ({AN, SEG, DP, FRAME} !== {4'hF, SOFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: got AN=%b SEG=%b DP=%b FRAME=%b exp AN=1111 SEG=1111111 DP=1 FRAME=0",
               name, AN, SEG, DP, FRAME);
    end
  endtask

  initial begin
    tbl.push_back(mk(16'h1234, 1'b1, S1, S2, S3, S4, 4'b0000));
    tbl.push_back(mk(16'h5678, 1'b1, S5, S6, S7, S8, 4'b0000));
    tbl.push_back(mk(16'h9012, 1'b0, S5, S6, S7, S8, 4'b0000));
`ifdef LEADING_ZERO_BLANK_EN
    tbl.push_back(mk(16'h00A0, 1'b1, SOFF, SOFF, SDASH, S0, 4'b1100));
    tbl.push_back(mk(16'h9012, 1'b1, S9, S0, S1, S2, 4'b0000));
    tbl.push_back(mk(16'h0050, 1'b1, SOFF, SOFF, S5, S0, 4'b1100));
    tbl.push_back(mk(16'h0000, 1'b1, SOFF, SOFF, SOFF, S0, 4'b1110));
    tbl.push_back(mk(16'h3000, 1'b0, SOFF, SOFF, SOFF, S0, 4'b1110));
`else
    tbl.push_back(mk(16'h00A0, 1'b1, S0, S0, SDASH, S0, 4'b0000));
    tbl.push_back(mk(16'h9012, 1'b1, S9, S0, S1, S2, 4'b0000));
`endif

    #12;
    check_rst("reset_state");

    @(posedge invCP);
    apply(tbl[0]);
    invCLR   = 1'b1;
    tracking = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) apply(tbl[i]);
      repeat (8) step();
      DIGITS = 16'h9876;
      repeat (FP - 8) step();
    end

    // Run into the SHOW slot of digit 2, then pull reset asynchronously.
    apply(mk(16'h2468, 1'b1, S2, S4, S6, S8, 4'b0000));
    repeat (2 * (SD + 1) + 2) step();
    #2;
    invCLR   = 1'b0;
    tracking = 1'b0;
    #1;
    check_rst("reset_mid_show");
    repeat (3) @(posedge invCP);
    check_rst("reset_held");

    apply(mk(16'h4321, 1'b1, S4, S3, S2, S1, 4'b0000));
    k        = 0;
    invCLR   = 1'b1;
    tracking = 1'b1;
    repeat (FP + 1) step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left exp 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
